// File: rtl/voice_bank.sv
// voice_bank: time-multiplexed bank of oscillator + envelope voices.
// A sweep runs one voice per clock through a two-stage pipeline
// (stage 0: waveform/phase/envelope, stage 1: scale and accumulate);
// the enveloped voices are averaged into one mixed sample per sweep.
module voice_bank #(
    parameter  int NUM_VOICES  = 4,
    parameter  int BITDEPTH    = 14,
    parameter  int BITFRACTION = 8,
    localparam int VW          = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_tick,
    input  logic                cfg_we,
    input  logic [VW-1:0]       cfg_voice,
    input  logic [1:0]          cfg_addr,
    input  logic [15:0]         cfg_wdata,
    output logic [BITDEPTH-1:0] mix_out,
    output logic                mix_valid,
    output logic                busy,
    output logic                overrun
);

    localparam int P  = BITDEPTH + BITFRACTION;
    localparam int AW = BITDEPTH + VW;
    localparam logic [VW-1:0] LAST_IDX = VW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_st_e;

    // Configuration register arrays
    logic [15:0] pitch_q  [NUM_VOICES];
    logic [7:0]  attack_q [NUM_VOICES];
    logic [7:0]  decay_q  [NUM_VOICES];
    logic [7:0]  pw_q     [NUM_VOICES];
    logic [2:0]  wf_q     [NUM_VOICES];
    logic        gate_q   [NUM_VOICES];

    // Per-voice running state
    logic [P-1:0] phase_q  [NUM_VOICES];
    logic [15:0]  env_q    [NUM_VOICES];
    env_st_e      st_q     [NUM_VOICES];
    logic [15:0]  lfsr_q;

    // Sweep control and pipeline
    logic                busy_q;
    logic                s0_act_q;
    logic [VW-1:0]       s0_idx_q;
    logic                s1_act_q;
    logic                s1_last_q;
    logic [BITDEPTH-1:0] s1_wave_q;
    logic [7:0]          s1_env_q;
    logic [AW-1:0]       acc_q;
    logic [BITDEPTH-1:0] mix_q;
    logic                mix_valid_q;
    logic                overrun_q;

    // Stage-0 combinational results
    logic [P-1:0]        cur_phase;
    logic [15:0]         cur_env;
    env_st_e             cur_st;
    logic                cur_gate;
    logic [7:0]          cur_attack;
    logic [7:0]          cur_decay;
    logic [BITDEPTH-1:0] wave;
    logic [P-1:0]        phase_d;
    logic [15:0]         env_d;
    env_st_e             st_d;
    logic [15:0]         lfsr_d;
    logic [16:0]         att_sum;
    logic [15:0]         att_env;
    logic [15:0]         dec_step;
    logic [15:0]         rel_env;

    // Stage-1 combinational results
    logic [BITDEPTH+7:0] prod;
    logic [BITDEPTH-1:0] voice_out;
    logic [AW-1:0]       acc_sum;
    logic                tick_accept;
    logic                unused_prod_bits;

    // A tick in the mix_valid cycle starts the next sweep; otherwise busy blocks it.
    assign tick_accept = sample_tick && (!busy_q || mix_valid_q);

    // Config writes: a voice in stage 0 this cycle still sees the old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                pitch_q[i]  <= 16'h0000;
                attack_q[i] <= 8'h00;
                decay_q[i]  <= 8'h00;
                pw_q[i]     <= 8'h00;
                wf_q[i]     <= 3'd0;
                gate_q[i]   <= 1'b0;
            end
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0: pitch_q[cfg_voice] <= cfg_wdata;
                2'd1: begin
                    attack_q[cfg_voice] <= cfg_wdata[15:8];
                    decay_q[cfg_voice]  <= cfg_wdata[7:0];
                end
                2'd2: begin
                    pw_q[cfg_voice] <= cfg_wdata[15:8];
                    wf_q[cfg_voice] <= cfg_wdata[2:0];
                end
                2'd3: gate_q[cfg_voice] <= cfg_wdata[0];
                default: ;
            endcase
        end
    end

    // Stage 0: waveform select, phase advance, envelope step for the current voice.
    always_comb begin
        cur_phase  = phase_q[s0_idx_q];
        cur_env    = env_q[s0_idx_q];
        cur_st     = st_q[s0_idx_q];
        cur_gate   = gate_q[s0_idx_q];
        cur_attack = attack_q[s0_idx_q];
        cur_decay  = decay_q[s0_idx_q];
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        phase_d    = cur_phase + P'(pitch_q[s0_idx_q]);

        case (wf_q[s0_idx_q])
            3'd0: wave = cur_phase[P-1 -: BITDEPTH];
            3'd1: wave = cur_phase[P-1] ? {BITDEPTH{1'b0}} : {BITDEPTH{1'b1}};
            3'd2: wave = cur_phase[P-1] ? ~cur_phase[P-2 -: BITDEPTH] : cur_phase[P-2 -: BITDEPTH];
            3'd3: wave = (cur_phase[P-1 -: 8] < pw_q[s0_idx_q]) ? {BITDEPTH{1'b1}} : {BITDEPTH{1'b0}};
            3'd4: wave = lfsr_q[15 -: BITDEPTH];
            default: wave = {BITDEPTH{1'b0}};
        endcase

        att_sum  = {1'b0, cur_env} + {5'b00000, cur_attack, 4'h0};
        dec_step = {4'h0, cur_decay, 4'h0};
        if (cur_attack == 8'h00) begin
            att_env = 16'hFFFF;
        end else if (att_sum[16]) begin
            att_env = 16'hFFFF;
        end else begin
            att_env = att_sum[15:0];
        end
        if (cur_decay == 8'h00) begin
            rel_env = 16'h0000;
        end else if (cur_env < dec_step) begin
            rel_env = 16'h0000;
        end else begin
            rel_env = cur_env - dec_step;
        end

        env_d = cur_env;
        st_d  = cur_st;
        case (cur_st)
            ST_IDLE: begin
                if (cur_gate) st_d = ST_ATTACK;
                else          st_d = ST_IDLE;
            end
            ST_ATTACK: begin
                // Gate release wins over the attack increment.
                if (!cur_gate) begin
                    st_d = ST_RELEASE;
                end else begin
                    env_d = att_env;
                    if (att_env == 16'hFFFF) st_d = ST_SUSTAIN;
                    else                     st_d = ST_ATTACK;
                end
            end
            ST_SUSTAIN: begin
                if (!cur_gate) st_d = ST_RELEASE;
                else           st_d = ST_SUSTAIN;
            end
            ST_RELEASE: begin
                if (cur_gate) begin
                    st_d = ST_ATTACK;
                end else begin
                    env_d = rel_env;
                    if (rel_env == 16'h0000) st_d = ST_IDLE;
                    else                     st_d = ST_RELEASE;
                end
            end
            default: begin
                st_d  = ST_IDLE;
                env_d = 16'h0000;
            end
        endcase
    end

    // Stage 1: scale the waveform by the envelope and add it to the running sum.
    always_comb begin
        prod      = (BITDEPTH + 8)'(s1_wave_q) * (BITDEPTH + 8)'(s1_env_q);
        voice_out = prod[BITDEPTH+7:8];
        acc_sum   = acc_q + AW'(voice_out);
    end

    assign unused_prod_bits = ^prod[7:0];

    // Per-voice state update; only the voice in stage 0 changes, and only during a sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= {P{1'b0}};
                env_q[i]   <= 16'h0000;
                st_q[i]    <= ST_IDLE;
            end
            lfsr_q <= 16'hACE1;
        end else if (s0_act_q) begin
            phase_q[s0_idx_q] <= phase_d;
            env_q[s0_idx_q]   <= env_d;
            st_q[s0_idx_q]    <= st_d;
            if (wf_q[s0_idx_q] == 3'd4) lfsr_q <= lfsr_d;
        end
    end

    // Sweep sequencing, pipeline registers, mix output and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            s0_act_q    <= 1'b0;
            s0_idx_q    <= {VW{1'b0}};
            s1_act_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_wave_q   <= {BITDEPTH{1'b0}};
            s1_env_q    <= 8'h00;
            acc_q       <= {AW{1'b0}};
            mix_q       <= {BITDEPTH{1'b0}};
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mix_valid_q <= 1'b0;
            if (tick_accept) begin
                busy_q   <= 1'b1;
                s0_act_q <= 1'b1;
                s0_idx_q <= {VW{1'b0}};
                acc_q    <= {AW{1'b0}};
            end else begin
                if (s0_act_q) begin
                    s0_idx_q <= s0_idx_q + VW'(1);
                    if (s0_idx_q == LAST_IDX) s0_act_q <= 1'b0;
                end
                if (s1_act_q) begin
                    acc_q <= acc_sum;
                    if (s1_last_q) begin
                        mix_q       <= acc_sum[AW-1:VW];
                        mix_valid_q <= 1'b1;
                    end
                end
                if (mix_valid_q) busy_q <= 1'b0;
            end
            s1_act_q  <= s0_act_q;
            s1_last_q <= s0_act_q && (s0_idx_q == LAST_IDX);
            s1_wave_q <= wave;
            s1_env_q  <= env_d[15:8];
            if (sample_tick && busy_q && !mix_valid_q) overrun_q <= 1'b1;
        end
    end

    assign mix_out   = mix_q;
    assign mix_valid = mix_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_bank.sv
// Scoreboard bench for voice_bank: stimulus pushes expected mix samples,
// a negedge monitor pops and compares on every mix_valid.
module tb_voice_bank;

    localparam int NV = 4;
    localparam int BD = 14;
    localparam int VW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_tick = 1'b0;
    logic          cfg_we = 1'b0;
    logic [VW-1:0] cfg_voice = '0;
    logic [1:0]    cfg_addr = 2'd0;
    logic [15:0]   cfg_wdata = 16'h0000;
    logic [BD-1:0] mix_out;
    logic          mix_valid;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    logic [BD-1:0] exp_q[$];

    voice_bank #(.NUM_VOICES(NV), .BITDEPTH(BD), .BITFRACTION(8)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .mix_out(mix_out), .mix_valid(mix_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every mix_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && mix_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mix_unexpected: got %0h expected none", mix_out);
            end else begin
                logic [BD-1:0] e;
                e = exp_q.pop_front();
                if (mix_out !== e) begin
                    errors++;
                    $display("FAIL mix_value: got %0h expected %0h", mix_out, e);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sample_tick = 1'b0;
        cfg_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg_wr(input int v, input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_voice = VW'(v);
        cfg_addr = a;
        cfg_wdata = d;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic voice_cfg(input int v, input logic [15:0] inc, input logic [15:0] ad,
                             input logic [15:0] pwwf, input logic [15:0] gate);
        cfg_wr(v, 2'd0, inc);
        cfg_wr(v, 2'd1, ad);
        cfg_wr(v, 2'd2, pwwf);
        cfg_wr(v, 2'd3, gate);
    endtask

    task automatic do_tick(input logic [BD-1:0] exp);
        exp_q.push_back(exp);
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    // Cycle-accurate sweep: optional extra tick at T+3 (overrun) or at T+6 (back-to-back).
    task automatic timed_sweep(input logic [BD-1:0] exp, input bit ovr, input bit b2b,
                               input logic [BD-1:0] exp2);
        exp_q.push_back(exp);
        if (b2b) exp_q.push_back(exp2);
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            chk("busy_window", busy, 1);
            chk("valid_timing", mix_valid, (i == 6) ? 1 : 0);
            if (ovr && i == 3) sample_tick = 1'b1;
            if (ovr && i == 4) begin
                sample_tick = 1'b0;
                chk("overrun_set", overrun, 1);
            end
            if (b2b && i == 6) sample_tick = 1'b1;
            @(posedge clk);
            #1;
        end
        sample_tick = 1'b0;
        if (b2b) begin
            chk("busy_b2b", busy, 1);
            chk("overrun_b2b", overrun, 0);
            repeat (6) @(posedge clk);
            #1;
        end
        chk("busy_after", busy, 0);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Enveloped, averaged single-voice contribution with env[15:8] = e8.
    function automatic logic [BD-1:0] one_voice_mix(input logic [BD-1:0] w, input logic [7:0] e8);
        logic [31:0] vo;
        vo = (32'(w) * 32'(e8)) >> 8;
        return BD'(vo >> 2);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [21:0] ph;
        logic [15:0] lf;
        logic [31:0] env;
        logic [BD-1:0] w;

        do_reset();
        #1;
        chk("rst_mix_out", mix_out, 0);
        chk("rst_mix_valid", mix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);

        // Idle bank: silent output, exact timing, no overrun.
        timed_sweep(14'h0, 1'b0, 1'b0, 14'h0);
        do_tick(14'h0);
        do_tick(14'h0);
        chk("no_overrun", overrun, 0);

        // Saw, inc 0x100, instant attack: sweep k sees wave k-1, voice_out k-2.
        do_reset();
        voice_cfg(0, 16'h0100, 16'h0000, 16'h0000, 16'h0001);
        for (int k = 1; k <= 10; k++)
            do_tick((k < 2) ? 14'h0 : BD'((k - 2) >> 2));

        // Saw with large increment crossing the 22-bit phase wrap.
        do_reset();
        voice_cfg(0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001);
        ph = 22'h0;
        for (int k = 1; k <= 70; k++) begin
            do_tick((k < 2) ? 14'h0 : one_voice_mix(ph[21:8], 8'hFF));
            ph = ph + 22'(16'hFFFF);
        end

        // Square with attack 0xFF: linear ramp, saturate at sweep 18, then release at decay 0.
        do_reset();
        voice_cfg(1, 16'h0000, 16'hFF00, 16'h0001, 16'h0001);
        for (int k = 1; k <= 20; k++) begin
            if (k < 2) env = 32'h0;
            else if (k <= 17) env = 32'(k - 1) * 32'h0FF0;
            else env = 32'hFFFF;
            do_tick(one_voice_mix(14'h3FFF, env[15:8]));
        end
        cfg_wr(1, 2'd3, 16'h0000);
        do_tick(14'h0FEF);
        do_tick(14'h0000);
        do_tick(14'h0000);

        // All voices square at full envelope; back-to-back tick, overrun, then abort.
        do_reset();
        for (int v = 0; v < NV; v++)
            voice_cfg(v, 16'h0000, 16'h0000, 16'h0001, 16'h0001);
        do_tick(14'h0000);
        do_tick(14'h3FBF);
        timed_sweep(14'h3FBF, 1'b0, 1'b1, 14'h3FBF);
        timed_sweep(14'h3FBF, 1'b1, 1'b0, 14'h0);
        chk("overrun_sticky", overrun, 1);
        chk("mix_held", mix_out, 14'h3FBF);
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_mix_out", mix_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_overrun", overrun, 0);
        chk("abort_valid", mix_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Noise voice alone: LFSR advances once per sweep from 16'hACE1.
        do_reset();
        voice_cfg(2, 16'h0000, 16'h0000, 16'h0004, 16'h0001);
        lf = 16'hACE1;
        for (int k = 1; k <= 1000; k++) begin
            w = lf[15:2];
            do_tick((k < 2) ? 14'h0 : one_voice_mix(w, 8'hFF));
            lf = lfsr_step(lf);
        end

        repeat (10) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
